// File: rtl/pipe_mon_pkg.sv
// Shared types, constants and helpers for the pipeline performance monitor.
//   mon_state_e  : monitor FSM encoding (IDLE/RUN/DONE), visible on o_state
//   CNT_*        : performance counter indices
//   OP_LOAD/STORE: major opcodes decoded from the MEM-stage instruction
//   is_nop()     : canonical NOP / bubble detection for retired instructions
package pipe_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mon_state_e;

    localparam int unsigned NUM_CNT   = 8;
    localparam int unsigned CNT_SEL_W = 3;

    localparam int unsigned CNT_CYCLES  = 0;
    localparam int unsigned CNT_RETIRED = 1;
    localparam int unsigned CNT_STALLS  = 2;
    localparam int unsigned CNT_FLUSHES = 3;
    localparam int unsigned CNT_FWD     = 4;
    localparam int unsigned CNT_LOADS   = 5;
    localparam int unsigned CNT_STORES  = 6;
    localparam int unsigned CNT_DROPS   = 7;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned INSTR_W  = 32;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [INSTR_W-1:0]  NOP_INSTR = 32'h0000_0013;

    // addi x0,x0,0 and the all-zero bubble both count as NOPs
    function automatic logic is_nop(input logic [INSTR_W-1:0] instr);
        return (instr == NOP_INSTR) || (instr == '0);
    endfunction

endpackage

// File: rtl/perf_trace_fifo.sv
// First-word-fall-through FIFO holding retired {pc, instr} trace entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : synchronous flush of pointers and occupancy
//   push_i     : write request for data_i
//   data_i     : entry to enqueue
//   ready_i    : consumer pops the head when valid_o is high
//   valid_o    : head entry present (registered)
//   head_o     : head entry, forced to zero while empty
//   drop_c     : push refused this cycle (full and no simultaneous pop)
module perf_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic             drop_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             full;
    logic             pop;
    logic             wr_en;

    assign full  = (count_q == CW'(DEPTH));
    assign pop   = valid_q && ready_i;
    // a pop in the same cycle frees the slot the push needs
    assign wr_en = push_i && (!full || pop);
    assign drop_c = push_i && full && !pop;

    // pointer / occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(pop);
        end
        valid_d = (count_d != '0);
    end

    // control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // storage; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clk) begin
        if (wr_en && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign head_o  = valid_q ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline monitor for the 5-stage RISC-V datapath: saturating event
// counters with a registered read port, a retired-instruction trace FIFO
// and a programmable end-of-program detector.
//   clk, reset          : clock, asynchronous active-low reset
//   i_en / i_clear      : arm the monitor / synchronous clear to IDLE
//   i_stall, i_flush,
//   i_forwardA/B,
//   i_mem_instr         : datapath event taps
//   i_wb_pc/i_wb_instr  : retiring instruction
//   i_rf_*              : register-file write port (end detection)
//   i_end_reg/i_end_val : end condition (i_end_reg = 0 disables)
//   i_cnt_sel/o_cnt_value : counter read port, one cycle latency
//   o_trace_*/i_trace_ready : trace FIFO head and drain handshake
//   o_trace_overflow    : sticky, a trace entry was dropped
//   o_state, o_done     : monitor state and sticky end flag
module pipe_perf_monitor
    import pipe_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned XLEN        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  logic                 i_clear,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [1:0]           i_forwardA,
    input  logic [1:0]           i_forwardB,
    input  logic [XLEN-1:0]      i_mem_instr,
    input  logic [XLEN-1:0]      i_wb_pc,
    input  logic [XLEN-1:0]      i_wb_instr,
    input  logic                 i_rf_wen,
    input  logic [4:0]           i_rf_waddr,
    input  logic [XLEN-1:0]      i_rf_wdata,
    input  logic [4:0]           i_end_reg,
    input  logic [XLEN-1:0]      i_end_val,
    input  logic [CNT_SEL_W-1:0] i_cnt_sel,
    output logic [CNT_W-1:0]     o_cnt_value,
    output logic                 o_trace_valid,
    output logic [XLEN-1:0]      o_trace_pc,
    output logic [XLEN-1:0]      o_trace_instr,
    input  logic                 i_trace_ready,
    output logic                 o_trace_overflow,
    output logic [1:0]           o_state,
    output logic                 o_done
);

    localparam int unsigned TRACE_W = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    mon_state_e                    state_q, state_d;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]              cnt_val_q, cnt_val_d;
    logic                          done_q, done_d;
    logic                          ovf_q, ovf_d;

    logic                          run;
    logic                          wb_hi_zero;
    logic                          retire;
    logic                          push;
    logic                          drop;
    logic                          end_hit;
    logic [NUM_CNT-1:0]            evt;
    logic [TRACE_W-1:0]            trace_head;
    logic                          unused_mem_hi;

    assign run = (state_q == ST_RUN);

    // instruction bits above 32 (wide XLEN builds) must be zero for a NOP
    generate
        if (XLEN > INSTR_W) begin : g_wide_instr
            assign wb_hi_zero = (i_wb_instr[XLEN-1:INSTR_W] == '0);
        end else begin : g_narrow_instr
            assign wb_hi_zero = 1'b1;
        end
    endgenerate

    assign retire = !(wb_hi_zero && is_nop(i_wb_instr[INSTR_W-1:0]));
    assign push   = run && retire;

    // only the opcode field of the MEM instruction is decoded
    assign unused_mem_hi = ^i_mem_instr[XLEN-1:OPCODE_W];

    assign end_hit = i_rf_wen
                  && (i_end_reg != 5'd0)
                  && (i_rf_waddr == i_end_reg)
                  && (i_rf_wdata == i_end_val);

    // per-counter event strobes for this cycle
    always_comb begin
        evt              = '0;
        evt[CNT_CYCLES]  = 1'b1;
        evt[CNT_RETIRED] = retire;
        evt[CNT_STALLS]  = i_stall;
        evt[CNT_FLUSHES] = i_flush;
        evt[CNT_FWD]     = (i_forwardA != 2'd0) || (i_forwardB != 2'd0);
        evt[CNT_LOADS]   = (i_mem_instr[OPCODE_W-1:0] == OP_LOAD);
        evt[CNT_STORES]  = (i_mem_instr[OPCODE_W-1:0] == OP_STORE);
        evt[CNT_DROPS]   = drop;
    end

    // FSM next state; clear overrides every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_en)    state_d = ST_RUN;
            ST_RUN:  if (end_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (i_clear) begin
            state_d = ST_IDLE;
        end
    end

    // sticky flags
    always_comb begin
        done_d = done_q;
        ovf_d  = ovf_q;
        if (i_clear) begin
            done_d = 1'b0;
            ovf_d  = 1'b0;
        end else begin
            if (run && end_hit) done_d = 1'b1;
            if (drop)           ovf_d  = 1'b1;
        end
    end

    // saturating counters, active only in RUN (including the ending edge)
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (i_clear) begin
                cnt_d[i] = '0;
            end else if (run && evt[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // read port shows the pre-update value of the selected counter
    always_comb begin
        cnt_val_d = i_clear ? '0 : cnt_q[i_cnt_sel];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cnt_val_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cnt_val_q <= cnt_val_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    perf_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_trace_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (i_clear),
        .push_i  (push),
        .data_i  ({i_wb_pc, i_wb_instr}),
        .ready_i (i_trace_ready),
        .valid_o (o_trace_valid),
        .head_o  (trace_head),
        .drop_c  (drop)
    );

    assign o_trace_pc       = trace_head[TRACE_W-1:XLEN];
    assign o_trace_instr    = trace_head[XLEN-1:0];
    assign o_cnt_value      = cnt_val_q;
    assign o_trace_overflow = ovf_q;
    assign o_state          = state_q;
    assign o_done           = done_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Self-checking bench for pipe_perf_monitor (CNT_W=8, TRACE_DEPTH=4).
module tb_pipe_perf_monitor;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    logic             clk;
    logic             reset;
    logic             i_en, i_clear, i_stall, i_flush;
    logic [1:0]       i_forwardA, i_forwardB;
    logic [XLEN-1:0]  i_mem_instr, i_wb_pc, i_wb_instr;
    logic             i_rf_wen;
    logic [4:0]       i_rf_waddr;
    logic [XLEN-1:0]  i_rf_wdata;
    logic [4:0]       i_end_reg;
    logic [XLEN-1:0]  i_end_val;
    logic [2:0]       i_cnt_sel;
    logic [CNT_W-1:0] o_cnt_value;
    logic             o_trace_valid;
    logic [XLEN-1:0]  o_trace_pc, o_trace_instr;
    logic             i_trace_ready;
    logic             o_trace_overflow;
    logic [1:0]       o_state;
    logic             o_done;

    pipe_perf_monitor #(.CNT_W(CNT_W), .TRACE_DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .i_en(i_en), .i_clear(i_clear),
        .i_stall(i_stall), .i_flush(i_flush),
        .i_forwardA(i_forwardA), .i_forwardB(i_forwardB),
        .i_mem_instr(i_mem_instr), .i_wb_pc(i_wb_pc), .i_wb_instr(i_wb_instr),
        .i_rf_wen(i_rf_wen), .i_rf_waddr(i_rf_waddr), .i_rf_wdata(i_rf_wdata),
        .i_end_reg(i_end_reg), .i_end_val(i_end_val), .i_cnt_sel(i_cnt_sel),
        .o_cnt_value(o_cnt_value), .o_trace_valid(o_trace_valid),
        .o_trace_pc(o_trace_pc), .o_trace_instr(o_trace_instr),
        .i_trace_ready(i_trace_ready), .o_trace_overflow(o_trace_overflow),
        .o_state(o_state), .o_done(o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];
    bit  run_m = 1'b0;
    int  cyc_m = 0;

    typedef struct {
        logic       stall;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [2:0] sel;
        logic [7:0] exp_cnt;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // one clock; a valid head held with ready is checked against the scoreboard
    task automatic cycle();
        logic [63:0] e;
        if (i_trace_ready && o_trace_valid) begin
            if (sb.size() == 0) begin
                chk("trace_unexpected_pop", {o_trace_pc, o_trace_instr}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("trace_pc", 64'(o_trace_pc), 64'(e[63:32]));
                chk("trace_instr", 64'(o_trace_instr), 64'(e[31:0]));
            end
        end
        @(posedge clk);
        if (run_m) cyc_m++;
        #1;
    endtask

    task automatic drive_retire(input logic [31:0] pc, input logic [31:0] instr, input bit accept);
        i_wb_pc    = pc;
        i_wb_instr = instr;
        if (accept && instr != 32'h13 && instr != 32'h0) sb.push_back({pc, instr});
    endtask

    task automatic read_cnt(input logic [2:0] sel, input string name, input logic [7:0] exp);
        i_cnt_sel = sel;
        cycle();
        chk(name, 64'(o_cnt_value), 64'(exp));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_state"}, 64'(o_state), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
        chk({tag, "_ovf"}, 64'(o_trace_overflow), 64'd0);
        chk({tag, "_valid"}, 64'(o_trace_valid), 64'd0);
        chk({tag, "_pc"}, 64'(o_trace_pc), 64'd0);
        chk({tag, "_instr"}, 64'(o_trace_instr), 64'd0);
        chk({tag, "_cnt"}, 64'(o_cnt_value), 64'd0);
    endtask

    logic [31:0] tr_instr[8];
    logic [31:0] tr_mem[8];

    initial begin
        // stall, flush, fwdA, fwdB, sel, expected o_cnt_value (pre-update)
        vecs[0]  = '{0, 0, 0, 0, 0, 8'd0};
        vecs[1]  = '{1, 0, 0, 0, 0, 8'd1};
        vecs[2]  = '{0, 1, 0, 0, 2, 8'd1};
        vecs[3]  = '{0, 0, 1, 2, 3, 8'd1};
        vecs[4]  = '{1, 0, 0, 0, 0, 8'd4};
        vecs[5]  = '{0, 0, 0, 1, 4, 8'd1};
        vecs[6]  = '{1, 0, 0, 0, 2, 8'd2};
        vecs[7]  = '{0, 1, 0, 0, 2, 8'd3};
        vecs[8]  = '{0, 0, 0, 0, 3, 8'd2};
        vecs[9]  = '{0, 0, 0, 0, 4, 8'd2};
        vecs[10] = '{0, 0, 0, 0, 0, 8'd10};
        vecs[11] = '{0, 0, 0, 0, 2, 8'd3};
        vecs[12] = '{0, 0, 0, 0, 3, 8'd2};

        tr_instr = '{32'h00500093, 32'h00000013, 32'h00000000, 32'h00208133,
                     32'h00000013, 32'h40110233, 32'h00000000, 32'h0000a303};
        tr_mem   = '{32'h00002183, 32'h00312023, 32'h0, 32'h0000a283,
                     32'h00000013, 32'h0, 32'h0, 32'h0};

        reset = 1'b0;
        i_en = 0; i_clear = 0; i_stall = 0; i_flush = 0;
        i_forwardA = 0; i_forwardB = 0; i_mem_instr = 0;
        i_wb_pc = 0; i_wb_instr = 32'h13;
        i_rf_wen = 0; i_rf_waddr = 0; i_rf_wdata = 0;
        i_end_reg = 0; i_end_val = 0; i_cnt_sel = 0; i_trace_ready = 0;
        #12;
        check_all_zero("reset");
        reset = 1'b1;
        cycle();
        cycle();
        chk("idle_hold", 64'(o_state), 64'd0);

        // arm, then counter table
        i_en = 1'b1;
        cycle();
        i_en = 1'b0;
        run_m = 1'b1;
        chk("run_after_en", 64'(o_state), 64'd1);
        foreach (vecs[k]) begin
            i_stall = vecs[k].stall; i_flush = vecs[k].flush;
            i_forwardA = vecs[k].fa; i_forwardB = vecs[k].fb;
            i_cnt_sel = vecs[k].sel;
            cycle();
            chk($sformatf("vec%0d_cnt", k), 64'(o_cnt_value), 64'(vecs[k].exp_cnt));
        end
        i_stall = 0; i_flush = 0; i_forwardA = 0; i_forwardB = 0;

        // retire mix with NOPs, in-order trace, loads/stores
        i_trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_retire(32'h100 + 32'(i * 4), tr_instr[i], 1'b1);
            i_mem_instr = tr_mem[i];
            if (i == 0) begin
                #1;
                chk("no_bypass", 64'(o_trace_valid), 64'd0);
            end
            cycle();
            if (i == 0) chk("head_next_cycle", 64'(o_trace_valid), 64'd1);
        end
        drive_retire(32'h0, 32'h13, 1'b0);
        i_mem_instr = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("trace_drained", 64'(sb.size()), 64'd0);
        chk("trace_empty", 64'(o_trace_valid), 64'd0);
        read_cnt(3'd1, "retired", 8'd4);
        read_cnt(3'd5, "loads", 8'd2);
        read_cnt(3'd6, "stores", 8'd1);

        // overflow: 6 retires into a 4-deep FIFO with no consumer
        i_trace_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_retire(32'h200 + 32'(i * 4), 32'h00A00093 + 32'(i) * 32'h00100000, i < 4);
            cycle();
        end
        drive_retire(32'h0, 32'h13, 1'b0);
        read_cnt(3'd7, "drops", 8'd2);
        chk("overflow_set", 64'(o_trace_overflow), 64'd1);
        chk("full_valid", 64'(o_trace_valid), 64'd1);

        // full + pop + push in one cycle: accepted
        i_trace_ready = 1'b1;
        drive_retire(32'h300, 32'h00B00113, 1'b1);
        cycle();
        i_trace_ready = 1'b0;
        drive_retire(32'h0, 32'h13, 1'b0);
        read_cnt(3'd7, "no_drop_on_pop", 8'd2);
        i_trace_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("overflow_drained", 64'(sb.size()), 64'd0);
        chk("overflow_empty", 64'(o_trace_valid), 64'd0);
        i_trace_ready = 1'b0;

        // end detect disabled with register 0
        i_end_reg = 5'd0; i_end_val = 32'd100;
        i_rf_wen = 1'b1; i_rf_waddr = 5'd0; i_rf_wdata = 32'd100;
        cycle();
        i_rf_waddr = 5'd20;
        cycle();
        i_rf_wen = 1'b0;
        cycle();
        chk("endreg0_state", 64'(o_state), 64'd1);
        chk("endreg0_done", 64'(o_done), 64'd0);

        // end detect x20 == 100, with a retire on the ending edge
        i_end_reg = 5'd20;
        i_rf_wen = 1'b1; i_rf_waddr = 5'd20; i_rf_wdata = 32'd99;
        drive_retire(32'h400, 32'h06400a13, 1'b1);
        cycle();
        chk("no_end_on_99", 64'(o_state), 64'd1);
        i_rf_wdata = 32'd100;
        drive_retire(32'h404, 32'h00000a93, 1'b1);
        cycle();
        run_m = 1'b0;
        chk("done_state", 64'(o_state), 64'd2);
        chk("done_flag", 64'(o_done), 64'd1);
        i_rf_wen = 1'b0;
        i_stall = 1'b1;
        drive_retire(32'h408, 32'h00100093, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        i_stall = 1'b0;
        drive_retire(32'h0, 32'h13, 1'b0);
        read_cnt(3'd1, "frozen_retired", 8'd13);
        read_cnt(3'd0, "frozen_cycles", 8'((cyc_m > 255) ? 255 : cyc_m));
        read_cnt(3'd2, "frozen_stalls", 8'd3);
        chk("done_sticky", 64'(o_state), 64'd2);

        // FIFO drains in DONE; leave one entry for the clear
        i_trace_ready = 1'b1;
        cycle();
        i_trace_ready = 1'b0;
        cycle();
        chk("done_fifo_left", 64'(o_trace_valid), 64'd1);

        // clear from DONE
        i_clear = 1'b1;
        cycle();
        i_clear = 1'b0;
        sb.delete();
        cyc_m = 0;
        check_all_zero("clear");
        read_cnt(3'd1, "clear_retired", 8'd0);
        read_cnt(3'd7, "clear_drops", 8'd0);
        chk("clear_idle", 64'(o_state), 64'd0);

        // saturation of the cycle counter
        i_end_reg = 5'd0;
        i_en = 1'b1;
        cycle();
        i_en = 1'b0;
        run_m = 1'b1;
        i_cnt_sel = 3'd0;
        for (int i = 0; i < 300; i++) cycle();
        read_cnt(3'd0, "saturate", 8'hFF);

        // asynchronous reset mid-run with a non-empty, overflowed FIFO
        for (int i = 0; i < 5; i++) begin
            drive_retire(32'h500 + 32'(i * 4), 32'h00300193 + 32'(i) * 32'h00100000, i < 4);
            cycle();
        end
        drive_retire(32'h0, 32'h13, 1'b0);
        cycle();
        chk("pre_reset_valid", 64'(o_trace_valid), 64'd1);
        chk("pre_reset_ovf", 64'(o_trace_overflow), 64'd1);
        chk("pre_reset_cnt", 64'(o_cnt_value), 64'hFF);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        run_m = 1'b0;
        #10;
        reset = 1'b1;
        cycle();
        chk("post_reset_idle", 64'(o_state), 64'd0);
        chk("post_reset_empty", 64'(o_trace_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_perf_monitor.md
# pipe_perf_monitor

Synthesizable, parametrised pipeline monitor for the 5-stage RISC-V datapath. It takes the datapath debug taps (stall, flush, forwarding selects, MEM/WB instructions, register-file write port) and provides:
- saturating per-event performance counters, readable through a registered select port;
- a retired-instruction trace FIFO with a ready/valid drain;
- a programmable end-of-program detector.

It gives silicon and FPGA builds the cycle log the simulation bench prints, without `$display`.

## Interface
Parameters:
- `CNT_W`, 32: width of every performance counter (≥8).
- `TRACE_DEPTH`, 16: trace FIFO entries; power of two, ≥2.
- `XLEN`, 32: PC/instruction/data width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `i_en` in 1: arm monitor (IDLE→RUN).
- `i_clear` in 1: synchronous clear of counters, FIFO, flags; returns to IDLE.
- `i_stall` in 1: load-use stall this cycle.
- `i_flush` in 1: branch flush this cycle.
- `i_forwardA` in 2: ALU operand A forward select.
- `i_forwardB` in 2: ALU operand B forward select.
- `i_mem_instr` in XLEN: instruction in MEM.
- `i_wb_pc` in XLEN: PC in WB.
- `i_wb_instr` in XLEN: instruction in WB.
- `i_rf_wen` in 1: register-file write enable.
- `i_rf_waddr` in 5: register-file write address.
- `i_rf_wdata` in XLEN: register-file write data.
- `i_end_reg` in 5: end-detect register (0 disables).
- `i_end_val` in XLEN: end-detect value.
- `i_cnt_sel` in 3: counter select.
- `o_cnt_value` out CNT_W: selected counter, registered.
- `o_trace_valid` out 1: FIFO head valid.
- `o_trace_pc` out XLEN: head PC.
- `o_trace_instr` out XLEN: head instruction.
- `i_trace_ready` in 1: consumer pops head when valid.
- `o_trace_overflow` out 1: sticky, a retire was dropped.
- `o_state` out 2: 0 IDLE, 1 RUN, 2 DONE.
- `o_done` out 1: sticky, end condition met.

## Operation
- NOP: an instruction equal to 0x00000013 or 0x00000000. NOPs are never counted as retired and never traced.
- FSM states:
  - IDLE: no counting. Moves to RUN when `i_en`=1.
  - RUN: all counting active. Moves to DONE on the end condition.
  - DONE: counters frozen; the FIFO still drains. Leaves DONE only on `i_clear` or reset.
  - `i_clear` wins over every other transition.
- Counter indices (counted only in RUN):
  - 0 cycles
  - 1 retired (non-NOP in WB)
  - 2 stall cycles
  - 3 flush cycles
  - 4 forward cycles (`i_forwardA`≠0 or `i_forwardB`≠0; at most +1 per cycle)
  - 5 loads (`i_mem_instr[6:0]`=0000011)
  - 6 stores (`i_mem_instr[6:0]`=0100011)
  - 7 trace drops
- All counters saturate at all-ones and never wrap.
- End condition (RUN only): `i_rf_wen` && `i_end_reg`≠0 && `i_rf_waddr`==`i_end_reg` && `i_rf_wdata`==`i_end_val`.
- Events sampled on the same edge as the end condition are still counted.
- Trace push: in RUN, on every non-NOP retire, {`i_wb_pc`, `i_wb_instr`} is pushed.
  - FIFO full with no pop that cycle: the entry is dropped, counter 7 increments, and `o_trace_overflow` sets.
  - Full with a simultaneous pop: the push is accepted.
  - Empty: a push is not visible at the head until the next cycle, so no bypass.

## Timing
- Reset and `i_clear` values:
  - state IDLE;
  - all counters 0, `o_cnt_value` 0;
  - FIFO empty, `o_trace_valid` 0, `o_trace_pc` 0, `o_trace_instr` 0;
  - `o_trace_overflow` 0, `o_done` 0.
- Counters reflect an event sampled at edge N starting at edge N+1.
- `o_cnt_value` = counter[`i_cnt_sel`] as registered at edge N. This is a 1-cycle read latency and shows the pre-update value.
- `o_state`=RUN is visible the cycle after `i_en` is sampled.
- `o_done`=1 and `o_state`=DONE are visible the cycle after the end condition.
- FIFO is first-word-fall-through: the head is valid one cycle after the push edge. Pop happens at the edge where valid && ready.
- Reset asserted mid-operation: all state clears immediately and asynchronously. The FIFO contents are discarded.

## Structure
- Package `pipe_mon_pkg` holds:
  - state enum and counter index constants;
  - `OP_LOAD`, `OP_STORE`, `NOP_INSTR`;
  - an `is_nop()` function.
- Sub-module `perf_trace_fifo`, parametrised by depth and width. It contains the pointers, count, and the full/empty logic.
- The top-level module contains the FSM, the counter array, the end detector, and the read mux.

## Test plan
- Reset, then `i_en`; hold RUN for 10 cycles with 3 stalls and 2 flushes → counters read 0:10, 2:3, 3:2. Each `o_cnt_value` lags its select by 1 cycle.
- Retire a mix including 0x13 and 0x00000000 → only non-NOPs counted in counter 1 and traced, in order with correct PC/instr. Forward A=1 and B=2 in the same cycle → counter 4 +1.
- `TRACE_DEPTH`=4, `i_trace_ready`=0, 6 retires → 4 queued, counter 7=2, overflow=1. Full + pop + push in one cycle → no drop.
- `i_end_reg`=20, `i_end_val`=100, write x20=100 → `o_done`=1 next cycle and counters frozen, while the FIFO keeps draining. Same test with `i_end_reg`=0 → never done.
- `CNT_W`=8, 300 RUN cycles → counter 0 holds 255.
- Assert reset mid-run with a non-empty FIFO → all outputs 0 at once. Separately, `i_clear` in DONE → IDLE with zeroed counters and an empty FIFO.
